// File: rtl/complex_adaptive_kalman_pkg.sv
// complex_adaptive_kalman_pkg: shared FIR/MAC constants, accumulator sizing and tree level helpers
package complex_adaptive_kalman_pkg;

    localparam int FILTER_LENGTH = 32;
    localparam int FXP_WIDTH     = 16;

    typedef logic signed [FXP_WIDTH-1:0] fxp_t;

    // Full-precision accumulator width: product width plus growth of the adder tree
    function automatic int acc_w(input int n_taps, input int data_w);
        return 2 * data_w + $clog2(n_taps);
    endfunction

    // Operand count entering adder level l of a tree over n leaves
    function automatic int level_count(input int n, input int l);
        int r;
        r = n;
        for (int i = 0; i < l; i++) r = (r + 1) / 2;
        return r;
    endfunction

    localparam int ACC_WIDTH = acc_w(FILTER_LENGTH, FXP_WIDTH);

endpackage

// File: rtl/adaptive_fir_mac_tree_fir_adder_level.sv
// fir_adder_level: one registered pairwise adder level with stall enable and valid pass-through
module fir_adder_level #(
    parameter int N_IN  = 2,
    parameter int ACC_W = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               in_valid,
    input  logic [N_IN*ACC_W-1:0]              in_data,
    output logic                               out_valid,
    output logic [((N_IN+1)/2)*ACC_W-1:0]      out_data
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*ACC_W-1:0] nxt;

    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
        if (2 * i + 1 < N_IN) begin : g_add
            assign nxt[i*ACC_W +: ACC_W] = $signed(in_data[2*i*ACC_W +: ACC_W])
                                         + $signed(in_data[(2*i+1)*ACC_W +: ACC_W]);
        end else begin : g_pass
            assign nxt[i*ACC_W +: ACC_W] = in_data[2*i*ACC_W +: ACC_W];
        end
    end

    // Level register: advances with the whole pipeline, holds on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= nxt;
        end
    end

endmodule

// File: rtl/adaptive_fir_mac_tree.sv
// adaptive_fir_mac_tree: pipelined dot product (products, pairwise adder tree, shift/reduce stage).
// Optional FIR_MAC_SAT_EN: clamp to the OUT_W signed range with a sticky sat_flag; otherwise wrap.
module adaptive_fir_mac_tree
    import complex_adaptive_kalman_pkg::*;
#(
    parameter int N_TAPS    = FILTER_LENGTH,
    parameter int DATA_W    = FXP_WIDTH,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_TAPS*DATA_W-1:0] taps_in,
    input  logic [N_TAPS*DATA_W-1:0] coeff_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         fir_out,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef FIR_MAC_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    localparam int ACC_W = acc_w(N_TAPS, DATA_W);
    localparam int LVLS  = $clog2(N_TAPS);

    logic [N_TAPS*ACC_W-1:0] prod_d;
    logic [N_TAPS*ACC_W-1:0] prod_q;
    logic                    prod_v;
    logic signed [ACC_W-1:0] last_sum;
    logic                    last_v;
    logic [OUT_W-1:0]        res;

    // One global enable: every stage moves together unless the output is blocked
    assign in_ready = !(out_valid && !out_ready);

    for (genvar i = 0; i < N_TAPS; i++) begin : g_mul
        logic signed [2*DATA_W-1:0] p;
        assign p = $signed(taps_in[i*DATA_W +: DATA_W]) * $signed(coeff_in[i*DATA_W +: DATA_W]);
        assign prod_d[i*ACC_W +: ACC_W] = ACC_W'(p);
    end

    // Product stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_v <= 1'b0;
            prod_q <= '0;
        end else if (in_ready) begin
            prod_v <= in_valid;
            prod_q <= prod_d;
        end
    end

    for (genvar g = 0; g < LVLS; g++) begin : g_lvl
        logic [level_count(N_TAPS, g + 1)*ACC_W-1:0] sum;
        logic                                        v;
        if (g == 0) begin : g_first
            fir_adder_level #(.N_IN(N_TAPS), .ACC_W(ACC_W)) u_lvl (
                .clk(clk), .rst_n(rst_n), .en(in_ready),
                .in_valid(prod_v), .in_data(prod_q),
                .out_valid(v), .out_data(sum)
            );
        end else begin : g_next
            fir_adder_level #(.N_IN(level_count(N_TAPS, g)), .ACC_W(ACC_W)) u_lvl (
                .clk(clk), .rst_n(rst_n), .en(in_ready),
                .in_valid(g_lvl[g-1].v), .in_data(g_lvl[g-1].sum),
                .out_valid(v), .out_data(sum)
            );
        end
    end

    assign last_sum = g_lvl[LVLS-1].sum;
    assign last_v   = g_lvl[LVLS-1].v;

`ifdef FIR_MAC_SAT_EN
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    logic signed [EXT_W-1:0] ext;
    logic                    ovf;

    // Overflow when the bits above the OUT_W sign bit disagree with it
    assign ext = EXT_W'(last_sum >>> OUT_SHIFT);
    assign ovf = !((&ext[EXT_W-1:OUT_W-1]) || !(|ext[EXT_W-1:OUT_W-1]));
    assign res = !ovf ? ext[OUT_W-1:0]
               : ext[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

    // Sticky clamp indicator, set only when a valid beat enters the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_flag <= 1'b0;
        else if (in_ready && last_v && ovf) sat_flag <= 1'b1;
    end
`else
    assign res = OUT_W'(last_sum >>> OUT_SHIFT);
`endif

    // Output register: shifted and reduced result, held while blocked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fir_out   <= '0;
        end else if (in_ready) begin
            out_valid <= last_v;
            fir_out   <= res;
        end
    end

endmodule

// File: tb/tb_adaptive_fir_mac_tree.sv
// tb_adaptive_fir_mac_tree: scoreboard bench for a 32-tap and a 5-tap instance (FIR_MAC_SAT_EN aware)
module tb_adaptive_fir_mac_tree;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        bit          lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    int           cnt = 0;
    int           errors = 0;
    int           checks = 0;
    exp_t         q32[$];
    exp_t         q5[$];

    logic [511:0] taps32, coeff32;
    logic         iv32, rdy32, ov32, ordy32;
    logic [31:0]  fo32;
    logic [79:0]  taps5, coeff5;
    logic         iv5, rdy5, ov5, ordy5;
    logic [31:0]  fo5;
`ifdef FIR_MAC_SAT_EN
    logic         sat32, sat5;
`endif

    logic [511:0] bt[10];
    logic [511:0] bc[10];

    always #5 clk = ~clk;
    always @(posedge clk) cnt++;

    adaptive_fir_mac_tree #(.N_TAPS(32), .DATA_W(16), .OUT_W(32), .OUT_SHIFT(0)) u_d32 (
        .clk(clk), .rst_n(rst_n), .taps_in(taps32), .coeff_in(coeff32),
        .in_valid(iv32), .in_ready(rdy32), .fir_out(fo32), .out_valid(ov32), .out_ready(ordy32)
`ifdef FIR_MAC_SAT_EN
        , .sat_flag(sat32)
`endif
    );

    adaptive_fir_mac_tree #(.N_TAPS(5), .DATA_W(16), .OUT_W(32), .OUT_SHIFT(0)) u_d5 (
        .clk(clk), .rst_n(rst_n), .taps_in(taps5), .coeff_in(coeff5),
        .in_valid(iv5), .in_ready(rdy5), .fir_out(fo5), .out_valid(ov5), .out_ready(ordy5)
`ifdef FIR_MAC_SAT_EN
        , .sat_flag(sat5)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference dot product in 64-bit arithmetic, then saturate or wrap to 32 bits
    function automatic logic [31:0] model(input logic [511:0] t, input logic [511:0] c, input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++)
            s += longint'($signed(t[i*16 +: 16])) * longint'($signed(c[i*16 +: 16]));
`ifdef FIR_MAC_SAT_EN
        if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (s < -64'sh80000000) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    task automatic send32(input logic [511:0] t, input logic [511:0] c, input logic [31:0] e, input bit lat);
        taps32 = t;
        coeff32 = c;
        iv32 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20 && !rdy32; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        chk("accept32", rdy32, 1);
        if (rdy32) q32.push_back('{e, cnt, lat});
        @(posedge clk);
        #1;
        iv32 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ov32 && ordy32) begin
            chk("spurious32", 64'(q32.size() != 0), 1);
            if (q32.size() != 0) begin
                exp_t e;
                e = q32.pop_front();
                chk("data32", fo32, e.val);
                if (e.lat) chk("lat32", 64'(cnt - e.cyc), 7);
            end
        end
    end

    always @(negedge clk) begin
        if (ov5 && ordy5) begin
            chk("spurious5", 64'(q5.size() != 0), 1);
            if (q5.size() != 0) begin
                exp_t e;
                e = q5.pop_front();
                chk("data5", fo5, e.val);
                if (e.lat) chk("lat5", 64'(cnt - e.cyc), 5);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        rst_n = 1'b0;
        iv32 = 1'b0; iv5 = 1'b0; ordy32 = 1'b1; ordy5 = 1'b1;
        taps32 = '0; coeff32 = '0; taps5 = '0; coeff5 = '0;
        for (int b = 0; b < 10; b++)
            for (int i = 0; i < 16; i++) begin
                bt[b][i*32 +: 32] = $urandom;
                bc[b][i*32 +: 32] = $urandom;
            end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", ov32, 0);
        chk("rst_fir_out", fo32, 0);
        chk("rst_in_ready", rdy32, 1);
        chk("rst_out_valid5", ov5, 0);
`ifdef FIR_MAC_SAT_EN
        chk("rst_sat_flag", sat32, 0);
`endif
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_in_ready", rdy32, 1);
        chk("post_rst_fir_out", fo32, 0);

        send32({32{16'h0100}}, {32{16'h0100}}, 32'h00200000, 1);
        idle(10);

`ifdef FIR_MAC_SAT_EN
        send32({32{16'h7FFF}}, {32{16'h7FFF}}, 32'h7FFFFFFF, 1);
        idle(10);
        chk("sat_flag_set", sat32, 1);
        send32({32{16'h8000}}, {32{16'h7FFF}}, 32'h80000000, 1);
        idle(10);
        chk("sat_flag_sticky", sat32, 1);
`else
        send32({32{16'h7FFF}}, {32{16'h7FFF}}, 32'hFFE00020, 1);
        idle(10);
        send32({32{16'h8000}}, {32{16'h7FFF}}, 32'h00100000, 1);
        idle(10);
`endif

        taps5 = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        coeff5 = {5{16'd1}};
        iv5 = 1'b1;
        @(negedge clk);
        chk("accept5", rdy5, 1);
        q5.push_back('{32'd15, cnt, 1'b1});
        @(posedge clk);
        #1;
        iv5 = 1'b0;
        idle(8);

        j = 0;
        for (int cy = 0; cy < 30; cy++) begin
            ordy32 = !(cy >= 9 && cy <= 11);
            iv32 = (j < 10);
            if (j < 10) begin
                taps32 = bt[j];
                coeff32 = bc[j];
            end
            @(negedge clk);
            if (!ordy32) begin
                chk("stall_in_ready", rdy32, 0);
                chk("stall_out_valid", ov32, 1);
                if (q32.size() != 0) chk("stall_hold", fo32, q32[0].val);
            end
            if (iv32 && rdy32) begin
                q32.push_back('{model(bt[j], bc[j], 32), cnt, 1'b0});
                j++;
            end
            @(posedge clk);
            #1;
        end
        iv32 = 1'b0;
        ordy32 = 1'b1;
        chk("bp_all_accepted", 64'(j), 10);
        idle(10);

        send32({32{16'h0001}}, {32{16'h0002}}, 32'd64, 1);
        send32({32{16'h0003}}, {32{16'h0001}}, 32'd96, 1);
        send32({32{16'hFFFF}}, {32{16'h0001}}, 32'hFFFFFFE0, 1);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov32, 0);
        chk("midrst_fir_out", fo32, 0);
        chk("midrst_in_ready", rdy32, 1);
        q32.delete();
        idle(2);
        rst_n = 1'b1;
        send32(bt[3], bc[3], model(bt[3], bc[3], 32), 1);
        idle(15);

        for (int k = 0; k < 100 && (q32.size() != 0 || q5.size() != 0); k++) @(posedge clk);
        chk("drain", 64'(q32.size() + q5.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adaptive_fir_mac_tree.md
ADAPTIVE_FIR_MAC_TREE -- requirements
Module: adaptive_fir_mac_tree

Interface
- REQ-001 The block SHALL have parameter N_TAPS, default 32, number of taps (any value 2..128, power of two not required).
- REQ-002 The block SHALL have parameter DATA_W, default 16, signed width of each tap and coefficient.
- REQ-003 The block SHALL have parameter OUT_W, default 32, signed width of fir_out.
- REQ-004 The block SHALL have parameter OUT_SHIFT, default 0, arithmetic right shift applied to the full sum before output.
- REQ-005 The block SHALL have port clk, input, 1, single clock for all state.
- REQ-006 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
- REQ-007 The block SHALL have port taps_in, input, N_TAPS*DATA_W, packed taps, tap i at bits [(i+1)*DATA_W-1 -: DATA_W].
- REQ-008 The block SHALL have port coeff_in, input, N_TAPS*DATA_W, packed coefficients, same packing.
- REQ-009 The block SHALL have port in_valid, input, 1, input beat present.
- REQ-010 The block SHALL have port in_ready, output, 1, block accepts a beat this cycle.
- REQ-011 The block SHALL have port fir_out, output, OUT_W, signed dot product result.
- REQ-012 The block SHALL have port out_valid, output, 1, fir_out valid.
- REQ-013 The block SHALL have port out_ready, input, 1, downstream accepts fir_out.
- REQ-014 The block SHALL have port sat_flag, output, 1, sticky saturation indicator (present only with FIR_MAC_SAT_EN).

Function
- REQ-015 The block SHALL accept a beat on in_valid && in_ready and SHALL emit exactly one result per accepted beat, in order.
- REQ-016 The block SHALL compute sum over i of taps[i]*coeffs[i], full precision, internal width ACC_W = 2*DATA_W + clog2(N_TAPS).
- REQ-017 The block SHALL use stage 0 = registered products, stages 1..clog2(N_TAPS) = registered pairwise adder levels, final stage = shift/saturate register.
- REQ-018 Latency SHALL be exactly 2 + clog2(N_TAPS) cycles from acceptance to out_valid when no stall occurs.
- REQ-019 At any adder level with an odd operand count, the unpaired operand SHALL pass through unchanged; this is equivalent to zero padding.
- REQ-020 The pipeline SHALL stall as a whole when out_valid && !out_ready; while stalled, all stage registers and valids SHALL hold.
- REQ-021 in_ready SHALL equal !(out_valid && !out_ready), a combinational function of out_ready and registered out_valid.
- REQ-022 fir_out and out_valid SHALL be held stable while out_valid && !out_ready.
- REQ-023 Bubbles (invalid slots) SHALL propagate and SHALL NOT be compressed; a valid bit SHALL travel with each stage.
- REQ-024 The output SHALL be sum >>> OUT_SHIFT (arithmetic), then reduced to OUT_W per REQ-029/REQ-030.

Reset
- REQ-025 On rst_n low, all stage data and valid registers SHALL clear asynchronously.
- REQ-026 Outputs during and after reset SHALL be fir_out=0, out_valid=0, in_ready=1, sat_flag=0.
- REQ-027 A reset mid-operation SHALL discard all in-flight beats, and no result for them SHALL ever appear.
- REQ-028 Reset release SHALL be synchronous to clk: the first acceptance occurs on the first clock edge after deassertion.

Configuration
- REQ-029 With FIR_MAC_SAT_EN defined, results outside the OUT_W signed range SHALL clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1), and sat_flag SHALL set on the first clamp and stay set until reset.
- REQ-030 Without FIR_MAC_SAT_EN, the result SHALL be truncated to its low OUT_W bits (two's-complement wrap), and the sat_flag port and its logic SHALL be absent.

Structure
- REQ-031 The shared package complex_adaptive_kalman_pkg SHALL hold the default FILTER_LENGTH, FXP_WIDTH and ACC_WIDTH constants, the clog2-based ACC_W function, and typedef fxp_t (signed DATA_W).
- REQ-032 One sub-module, fir_adder_level, SHALL implement one registered pairwise adder level with a stall enable and valid pass-through, instantiated clog2(N_TAPS) times via generate.

Verification
- REQ-033 Basic: N_TAPS=32, all taps=coeffs=0x0100, one beat -> fir_out=0x00200000 with out_valid exactly 7 cycles after acceptance.
- REQ-034 Saturation: taps=coeffs=0x7FFF -> with FIR_MAC_SAT_EN, fir_out=0x7FFFFFFF and sat_flag=1; without it, fir_out=0xFFE00020. Also taps=0x8000, coeffs=0x7FFF with FIR_MAC_SAT_EN -> fir_out=0x80000000.
- REQ-035 Backpressure: 10 back-to-back beats with distinct values, out_ready low for 3 cycles mid-stream -> in_ready low in those cycles, all 10 results correct, in order, none duplicated.
- REQ-036 Odd length: N_TAPS=5, taps=1..5, coeffs=1 -> fir_out=15, latency 5 cycles.
- REQ-037 Reset mid-flight: assert rst_n low 2 cycles after 3 accepted beats -> out_valid=0, fir_out=0 immediately; no stale results after release; next beat has normal latency.
